// File: rtl/exc_code_arbiter.sv
// Debounces run/stop buttons, latches run/stop/UART/syscall events and issues one exception code at a time by fixed priority.
// Latency: pulse at edge N -> code after edge N+1, held PULSE_CYCLES then GAP_CYCLES of 0; no backpressure, events wait as pending bits.
module exc_code_arbiter #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  PULSE_CYCLES    = 4'd2,
  parameter logic [3:0]  GAP_CYCLES      = 4'd1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_run_i,
  input  logic       btn_stop_i,
  input  logic       uart_start_i,
  input  logic       uart_done_i,
  input  logic       sys_pause_i,
  input  logic       sys_resume_i,
  output logic [3:0] exc_code_o,
  output logic [5:0] pending_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  raw;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  deb;
  logic [15:0] deb_cnt [2];
  logic [1:0]  flip;
  logic [1:0]  rise;
  logic [5:0]  set;
  logic [5:0]  sel;
  logic [5:0]  clr;
  logic [3:0]  code;

  assign raw = {btn_stop_i, btn_run_i};

  always_comb begin
    flip = '0;
    rise = '0;
    for (int b = 0; b < 2; b++) begin
      flip[b] = (sync2[b] != deb[b]) && (deb_cnt[b] == DEBOUNCE_CYCLES - 16'd1);
      rise[b] = flip[b] && !deb[b];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == deb[b] || flip[b]) begin
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + 16'd1;
        end
        if (flip[b]) deb[b] <= sync2[b];
      end
    end
  end

  // Bit order {uart_start, uart_done, pause, resume, stop, run} is also the issue priority, MSB first.
  assign set = {uart_start_i, uart_done_i, sys_pause_i, sys_resume_i, rise[1], rise[0]};

  always_comb begin
    sel  = '0;
    code = 4'd0;
    if (pending_o[5]) begin
      sel = 6'b100000; code = 4'd5;
    end else if (pending_o[4]) begin
      sel = 6'b010000; code = 4'd6;
    end else if (pending_o[3]) begin
      sel = 6'b001000; code = 4'd2;
    end else if (pending_o[2]) begin
      sel = 6'b000100; code = 4'd3;
    end else if (pending_o[1]) begin
      sel = 6'b000010; code = 4'd4;
    end else if (pending_o[0]) begin
      sel = 6'b000001; code = 4'd1;
    end
  end

  assign clr = (state == IDLE) ? sel : 6'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_o <= '0;
    end else begin
      pending_o <= (pending_o & ~clr) | set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      exc_code_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending_o) begin
            state      <= ISSUE;
            exc_code_o <= code;
            busy_o     <= 1'b1;
            cnt        <= '0;
          end
        end
        ISSUE: begin
          if (cnt == PULSE_CYCLES - 4'd1) begin
            state      <= GAP;
            exc_code_o <= 4'd0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_CYCLES - 4'd1) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          exc_code_o <= 4'd0;
          busy_o     <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule
